// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants and types for the TDC frame collector
//
// Purpose: widths, FSM state type, flag bit positions and frame record type
//          shared by tdc_frame_collector, tdc_peak_tracker and their bench.
// Ports:   none (package).
package tdc_pkg;

   localparam int TDC_DW       = 15;   // depth (time) code width
   localparam int TDC_IW       = 5;    // intensity width
   localparam int TDC_FID_W    = 8;    // frame id counter width
   localparam int TDC_MAX_HITS = 4;    // hits kept per frame
   localparam int TDC_HIT_W    = 3;    // hit counter width, holds 0..MAX_HITS

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      EMIT    = 2'd2
   } state_e;

   localparam int FLG_OVF = 0;
   localparam int FLG_TMO = 1;
   localparam int FLG_SEQ = 2;

   typedef struct packed {
      logic [TDC_DW-1:0]    peak_depth;
      logic [TDC_IW-1:0]    peak_int;
      logic [TDC_DW-1:0]    first_depth;
      logic [TDC_HIT_W-1:0] hits;
      logic [2:0]           flags;
      logic [TDC_FID_W-1:0] frame_id;
   } frame_rec_t;

endpackage

// File: rtl/tdc_peak_tracker.sv
// rtl/tdc_peak_tracker.sv - running peak / first-hit / hit-count registers
//
// Purpose: holds the per-frame running record. load captures the first kept
//          hit, update folds in a later kept hit (strictly greater intensity
//          wins, ties keep the earlier hit), clear empties the record.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clear            zero the record (frame handed off)
//   load             first kept hit of the frame
//   update           later kept hit of the frame
//   depth, intensity hit being loaded/folded in
//   peak_depth       depth of the max-intensity hit
//   peak_int         intensity of that hit
//   first_depth      depth of the first kept hit
//   cnt              number of kept hits
module tdc_peak_tracker
   import tdc_pkg::*;
#(
   parameter int DW = TDC_DW,
   parameter int IW = TDC_IW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 update,
   input  logic [DW-1:0]        depth,
   input  logic [IW-1:0]        intensity,
   output logic [DW-1:0]        peak_depth,
   output logic [IW-1:0]        peak_int,
   output logic [DW-1:0]        first_depth,
   output logic [TDC_HIT_W-1:0] cnt
);

   logic [DW-1:0]        peak_depth_q,  peak_depth_d;
   logic [IW-1:0]        peak_int_q,    peak_int_d;
   logic [DW-1:0]        first_depth_q, first_depth_d;
   logic [TDC_HIT_W-1:0] cnt_q,         cnt_d;

   always_comb begin
      peak_depth_d  = peak_depth_q;
      peak_int_d    = peak_int_q;
      first_depth_d = first_depth_q;
      cnt_d         = cnt_q;
      if (clear) begin
         peak_depth_d  = '0;
         peak_int_d    = '0;
         first_depth_d = '0;
         cnt_d         = '0;
      end else if (load) begin
         peak_depth_d  = depth;
         peak_int_d    = intensity;
         first_depth_d = depth;
         cnt_d         = TDC_HIT_W'(1);
      end else if (update) begin
         cnt_d = cnt_q + TDC_HIT_W'(1);
         // strict compare: on a tie the earlier hit stays the peak
         if (intensity > peak_int_q) begin
            peak_depth_d = depth;
            peak_int_d   = intensity;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_depth_q  <= '0;
         peak_int_q    <= '0;
         first_depth_q <= '0;
         cnt_q         <= '0;
      end else begin
         peak_depth_q  <= peak_depth_d;
         peak_int_q    <= peak_int_d;
         first_depth_q <= first_depth_d;
         cnt_q         <= cnt_d;
      end
   end

   assign peak_depth  = peak_depth_q;
   assign peak_int    = peak_int_q;
   assign first_depth = first_depth_q;
   assign cnt         = cnt_q;

endmodule

// File: rtl/tdc_frame_collector.sv
// rtl/tdc_frame_collector.sv - reduces one TDC start-to-last frame to a record
//
// Purpose: consumes the tdc_top result stream, tracks peak / first hit / hit
//          count / flags over one frame and presents the frame record on a
//          valid/ready port. Optional build macro TDC_MIN_INT_FILT_EN drops
//          beats with s_int < MIN_INT before they reach the record.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   s_data/s_int/s_num/s_last         TDC beat (depth, intensity, index, last)
//   s_valid/s_ready                   TDC beat handshake
//   tdc_int                           TDC overflow/timeout, closes a frame
//   m_valid/m_ready                   frame record handshake
//   m_peak_depth/m_peak_int           max-intensity hit
//   m_first_depth                     first kept hit depth
//   m_hits                            kept hit count
//   m_flags                           {seq_err, timeout, ovf}
//   m_frame_id                        frame sequence number
module tdc_frame_collector
   import tdc_pkg::*;
#(
   parameter int DW       = TDC_DW,
   parameter int IW       = TDC_IW,
   parameter int MAX_HITS = TDC_MAX_HITS,
   parameter int FID_W    = TDC_FID_W,
   parameter int MIN_INT  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    s_data,
   input  logic [IW-1:0]    s_int,
   input  logic [1:0]       s_num,
   input  logic             s_last,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             tdc_int,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [DW-1:0]    m_peak_depth,
   output logic [IW-1:0]    m_peak_int,
   output logic [DW-1:0]    m_first_depth,
   output logic [2:0]       m_hits,
   output logic [2:0]       m_flags,
   output logic [FID_W-1:0] m_frame_id
);

   localparam logic [TDC_HIT_W-1:0] MAX_C = TDC_HIT_W'(MAX_HITS);

   state_e           state_q,    state_d;
   logic             s_ready_q,  s_ready_d;
   logic             m_valid_q,  m_valid_d;
   logic [2:0]       flags_q,    flags_d;
   logic [FID_W-1:0] frame_id_q, frame_id_d;

   logic [TDC_HIT_W-1:0] cnt;
   logic accept, candidate, room, keep;
   logic trk_load, trk_update, trk_clear;

   assign accept = s_valid & s_ready_q;

`ifdef TDC_MIN_INT_FILT_EN
   assign candidate = (s_int >= IW'(MIN_INT));
`else
   assign candidate = 1'b1;
   logic unused_min_int;
   assign unused_min_int = ^MIN_INT;
`endif

   assign room       = (cnt < MAX_C);
   assign keep       = accept & candidate & room;
   assign trk_load   = keep & (cnt == '0);
   assign trk_update = keep & (cnt != '0);
   assign trk_clear  = (state_q == EMIT) & m_ready;

   tdc_peak_tracker #(
      .DW (DW),
      .IW (IW)
   ) u_peak (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (trk_clear),
      .load        (trk_load),
      .update      (trk_update),
      .depth       (s_data),
      .intensity   (s_int),
      .peak_depth  (m_peak_depth),
      .peak_int    (m_peak_int),
      .first_depth (m_first_depth),
      .cnt         (cnt)
   );

   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q;
      frame_id_d = frame_id_q;

      // Flags only look at candidate beats; the sequence check is only made
      // on beats that are kept, since dropped beats have no slot to check.
      if (accept && candidate) begin
         if (!room) begin
            flags_d[FLG_OVF] = 1'b1;
         end else if (s_num != cnt[1:0]) begin
            flags_d[FLG_SEQ] = 1'b1;
         end
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = s_last ? EMIT : COLLECT;
            end
         end
         COLLECT: begin
            if (accept && s_last) begin
               state_d = EMIT;
            end
            // tdc_int alongside an accepted non-last beat does not close
            if (tdc_int && (!accept || s_last)) begin
               flags_d[FLG_TMO] = 1'b1;
               state_d          = EMIT;
            end
         end
         EMIT: begin
            if (m_ready) begin
               state_d    = IDLE;
               flags_d    = '0;
               frame_id_d = frame_id_q + FID_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // handshake outputs are registered from the next state
      s_ready_d = (state_d != EMIT);
      m_valid_d = (state_d == EMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         flags_q    <= '0;
         frame_id_q <= '0;
      end else begin
         state_q    <= state_d;
         s_ready_q  <= s_ready_d;
         m_valid_q  <= m_valid_d;
         flags_q    <= flags_d;
         frame_id_q <= frame_id_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign m_valid    = m_valid_q;
   assign m_hits     = cnt;
   assign m_flags    = flags_q;
   assign m_frame_id = frame_id_q;

endmodule
